// File: rtl/uart_rx_cfg.sv
// UART receiver with run-time frame format (5..DATA_W data bits, parity mode,
// 1/2 stop bits), 3-sample mid-bit majority vote and a small receive FIFO.
module uart_rx_cfg #(
  parameter int DATA_W     = 9,
  parameter int OSR        = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_en,
  input  logic              sample_tick,
  input  logic [3:0]        cfg_data_bits,
  input  logic [2:0]        cfg_parity,
  input  logic              cfg_stop2,
  input  logic              rxd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_parity_err,
  output logic              out_frame_err,
  output logic              out_break,
  output logic              overrun,
  input  logic              ovr_clr,
  output logic              busy
);

  localparam int CW = $clog2(OSR);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int WW = DATA_W + 3;
  localparam logic [CW-1:0] VOTE0  = CW'(OSR / 2 - 1);
  localparam logic [CW-1:0] VOTE1  = CW'(OSR / 2);
  localparam logic [CW-1:0] VOTE2  = CW'(OSR / 2 + 1);
  localparam logic [CW-1:0] LAST   = CW'(OSR - 1);
  localparam logic [3:0]    NB_MAX = 4'(DATA_W);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;
  typedef enum logic [2:0] {
    PAR_NONE  = 3'b000,
    PAR_EVEN  = 3'b001,
    PAR_ODD   = 3'b010,
    PAR_MARK  = 3'b011,
    PAR_SPACE = 3'b100
  } par_t;

  logic          rxd_m, rxd_s;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;
  logic [3:0]    bit_q, bit_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic          perr_q, perr_d, ferr_q, ferr_d, brk_q, brk_d, pbit_q, pbit_d;
  logic          s0_q, s0_d, s1_q, s1_d;
  logic [3:0]    nb_q, nb_d, nb_cfg;
  par_t          par_q, par_d, par_cfg;
  logic          stop2_q, stop2_d;
  logic          push_q, push_d;
  logic [WW-1:0] word_q, word_d;
  logic          voted, par_exp;

  logic [WW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [PW:0]   fcnt_q;
  logic          full, pop, wr_en;
  logic [WW-1:0] head;

  // Two-flop synchronizer for the asynchronous serial line (idles high).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  // Clamp data-bit count and fold reserved parity codes to none.
  always_comb begin
    nb_cfg = cfg_data_bits;
    if (cfg_data_bits < 4'd5)        nb_cfg = 4'd5;
    else if (cfg_data_bits > NB_MAX) nb_cfg = NB_MAX;
    par_cfg = (cfg_parity <= 3'b100) ? par_t'(cfg_parity) : PAR_NONE;
  end

  // Frame FSM and datapath state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      armed_q <= 1'b0;
      bit_q   <= '0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
      pbit_q  <= 1'b0;
      s0_q    <= 1'b1;
      s1_q    <= 1'b1;
      nb_q    <= 4'd5;
      par_q   <= PAR_NONE;
      stop2_q <= 1'b0;
      push_q  <= 1'b0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      brk_q   <= brk_d;
      pbit_q  <= pbit_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      nb_q    <= nb_d;
      par_q   <= par_d;
      stop2_q <= stop2_d;
      push_q  <= push_d;
      word_q  <= word_d;
    end
  end

  // Next-state logic: all progress gated by sample_tick while enabled.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    armed_d = armed_q;
    bit_d   = bit_q;
    data_d  = data_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    brk_d   = brk_q;
    pbit_d  = pbit_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    nb_d    = nb_q;
    par_d   = par_q;
    stop2_d = stop2_q;
    push_d  = 1'b0;
    word_d  = word_q;
    voted   = (s0_q & s1_q) | (s0_q & rxd_s) | (s1_q & rxd_s);
    case (par_q)
      PAR_EVEN: par_exp = ^data_q;
      PAR_ODD:  par_exp = ~^data_q;
      PAR_MARK: par_exp = 1'b1;
      default:  par_exp = 1'b0;
    endcase

    if (!rx_en) begin
      state_d = IDLE;
      cnt_d   = '0;
      armed_d = 1'b0;
      bit_d   = '0;
    end else if (sample_tick) begin
      if (cnt_q == VOTE0) s0_d = rxd_s;
      if (cnt_q == VOTE1) s1_d = rxd_s;
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (armed_q && !rxd_s) begin
            state_d = START;
            armed_d = 1'b0;
            nb_d    = nb_cfg;
            par_d   = par_cfg;
            stop2_d = cfg_stop2;
            data_d  = '0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
            brk_d   = 1'b0;
            pbit_d  = 1'b0;
            bit_d   = '0;
          end else if (rxd_s) begin
            armed_d = 1'b1;
          end
        end
        START: begin
          if (cnt_q == VOTE2 && voted) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == LAST) begin
            state_d = DATA;
            bit_d   = '0;
          end
        end
        DATA: begin
          if (cnt_q == VOTE2) begin
            for (int unsigned i = 0; i < DATA_W; i++) begin
              if (i == 32'(bit_q)) data_d[i] = voted;
            end
          end
          if (cnt_q == LAST) begin
            if (bit_q == nb_q - 4'd1)
              state_d = (par_q != PAR_NONE) ? PARITY : STOP1;
            else
              bit_d = bit_q + 4'd1;
          end
        end
        PARITY: begin
          if (cnt_q == VOTE2) begin
            pbit_d = voted;
            perr_d = (voted != par_exp);
          end
          if (cnt_q == LAST) state_d = STOP1;
        end
        STOP1: begin
          if (cnt_q == VOTE2) begin
            ferr_d = ~voted;
            brk_d  = (data_q == '0) & ~pbit_q & ~voted;
            if (!stop2_q) begin
              push_d  = 1'b1;
              word_d  = {data_q, perr_q, ~voted, (data_q == '0) & ~pbit_q & ~voted};
              state_d = IDLE;
              cnt_d   = '0;
            end
          end else if (cnt_q == LAST) begin
            state_d = STOP2;
          end
        end
        STOP2: begin
          if (cnt_q == VOTE2) begin
            push_d  = 1'b1;
            word_d  = {data_q, perr_q, ferr_q | ~voted, brk_q};
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign busy  = (state_q != IDLE);
  assign full  = (fcnt_q == (PW+1)'(FIFO_DEPTH));
  assign pop   = out_valid & out_ready;
  assign wr_en = push_q & (~full | pop);

  // FIFO storage; head visibility is gated by out_valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wp_q] <= word_q;
  end

  // FIFO pointers, occupancy and sticky overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      fcnt_q  <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr_en) wp_q <= wp_q + PW'(1);
      if (pop)   rp_q <= rp_q + PW'(1);
      if (wr_en && !pop)      fcnt_q <= fcnt_q + (PW+1)'(1);
      else if (!wr_en && pop) fcnt_q <= fcnt_q - (PW+1)'(1);
      if (push_q && full && !pop) overrun <= 1'b1;
      else if (ovr_clr)           overrun <= 1'b0;
    end
  end

  assign out_valid      = (fcnt_q != '0);
  assign head           = mem[rp_q];
  assign out_data       = out_valid ? head[WW-1:3] : '0;
  assign out_parity_err = out_valid & head[2];
  assign out_frame_err  = out_valid & head[1];
  assign out_break      = out_valid & head[0];

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: frames are described at the bit level,
// expected entries are queued when a frame is sent and popped by a monitor.
module tb_uart_rx_cfg;

  localparam int TICKDIV = 4;
  localparam int BITCLK  = 16 * TICKDIV;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_en;
  logic       sample_tick;
  logic [3:0] cfg_data_bits;
  logic [2:0] cfg_parity;
  logic       cfg_stop2;
  logic       rxd;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] out_data;
  logic       out_parity_err, out_frame_err, out_break;
  logic       overrun;
  logic       ovr_clr;
  logic       busy;

  typedef struct {
    logic [8:0] d;
    logic       perr;
    logic       ferr;
    logic       brk;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   rdy_mode = 1;

  uart_rx_cfg #(.DATA_W(9), .OSR(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .rx_en(rx_en), .sample_tick(sample_tick),
    .cfg_data_bits(cfg_data_bits), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
    .rxd(rxd), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_parity_err(out_parity_err), .out_frame_err(out_frame_err),
    .out_break(out_break), .overrun(overrun), .ovr_clr(ovr_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  initial begin
    int div = 0;
    sample_tick = 1'b0;
    forever begin
      @(posedge clk); #1;
      div = (div + 1) % TICKDIV;
      sample_tick = (div == 0);
    end
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 1) == 1);
      endcase
    end
  end

  // Monitor: every accepted head entry must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      chk("sb_nonempty_on_pop", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("data", out_data, e.d);
        chk("parity_err", out_parity_err, e.perr);
        chk("frame_err", out_frame_err, e.ferr);
        chk("break", out_break, e.brk);
      end
    end
  end

  task automatic bit_time(input logic v);
    rxd = v;
    repeat (BITCLK) @(negedge clk);
  endtask

  // Reference: frame described from the format rules, expectation queued first.
  task automatic send_frame(input logic [8:0] d, input logic [3:0] nbc, input logic [2:0] par,
                            input bit st2, input bit bad_par, input bit bad_st1,
                            input bit bad_st2, input bit push_exp, input bit scramble);
    int   nb;
    logic [8:0] dm;
    bit   pen, expp, sent, st1b, st2b;
    exp_t e;
    nb = (nbc < 5) ? 5 : ((nbc > 9) ? 9 : int'(nbc));
    dm = '0;
    for (int i = 0; i < 9; i++) if (i < nb) dm[i] = d[i];
    pen  = (par >= 3'd1 && par <= 3'd4);
    case (par)
      3'd1:    expp = ^dm;
      3'd2:    expp = ~^dm;
      3'd3:    expp = 1'b1;
      default: expp = 1'b0;
    endcase
    sent = expp ^ bad_par;
    st1b = ~bad_st1;
    st2b = ~bad_st2;
    e.d    = dm;
    e.perr = pen & bad_par;
    e.ferr = !st1b || (st2 && !st2b);
    e.brk  = (dm == 0) && (!pen || !sent) && !st1b;
    if (push_exp) sb.push_back(e);
    cfg_data_bits = nbc;
    cfg_parity    = par;
    cfg_stop2     = st2;
    bit_time(1'b0);
    if (scramble) begin
      cfg_data_bits = 4'($urandom);
      cfg_parity    = 3'($urandom);
      cfg_stop2     = 1'($urandom);
    end
    for (int i = 0; i < nb; i++) bit_time(dm[i]);
    if (pen) bit_time(sent);
    bit_time(st1b);
    if (st2) bit_time(st2b);
    bit_time(1'b1);
    bit_time(1'b1);
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((sb.size() != 0 || out_valid) && k < 4000) begin
      @(negedge clk);
      k++;
    end
    chk("drain_left", sb.size(), 0);
    chk("drain_valid", out_valid, 0);
  endtask

  initial begin
    int saw_busy;
    rst_n = 1'b0; rx_en = 1'b1; rxd = 1'b1; ovr_clr = 1'b0;
    cfg_data_bits = 4'd8; cfg_parity = 3'd0; cfg_stop2 = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", out_data, 0);
    rst_n = 1'b1;
    bit_time(1'b1);

    // 8N1 0xA5
    send_frame(9'h0A5, 4'd8, 3'd0, 0, 0, 0, 0, 1, 0);
    wait_drain();
    // 7E2 0x35, wrong parity
    send_frame(9'h035, 4'd7, 3'd1, 1, 1, 0, 0, 1, 0);
    // 9O2 0x1FF good, then STOP2 low
    send_frame(9'h1FF, 4'd9, 3'd2, 1, 0, 0, 0, 1, 0);
    send_frame(9'h1FF, 4'd9, 3'd2, 1, 0, 0, 1, 1, 0);
    // mark / space / clamp cases
    send_frame(9'h012, 4'd2, 3'd3, 0, 0, 0, 0, 1, 0);
    send_frame(9'h155, 4'd15, 3'd4, 0, 1, 0, 0, 1, 0);
    wait_drain();

    // Short low glitch: false start only.
    cfg_data_bits = 4'd8; cfg_parity = 3'd0; cfg_stop2 = 1'b0;
    saw_busy = 0;
    rxd = 1'b0;
    repeat (6 * TICKDIV) begin @(negedge clk); if (busy) saw_busy = 1; end
    rxd = 1'b1;
    repeat (3 * BITCLK) begin @(negedge clk); if (busy) saw_busy = 1; end
    chk("glitch_busy_pulse", saw_busy, 1);
    chk("glitch_busy_end", busy, 0);
    chk("glitch_no_push", out_valid, 0);

    // Line held low for 3 frame times: a single break entry.
    sb.push_back('{d: 9'h000, perr: 1'b0, ferr: 1'b1, brk: 1'b1});
    rxd = 1'b0;
    repeat (30 * BITCLK) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * BITCLK) @(negedge clk);
    wait_drain();

    // Overrun with consumer stalled.
    rdy_mode = 0;
    for (int i = 0; i < 5; i++)
      send_frame(9'($urandom), 4'd8, 3'd0, 0, 0, 0, 0, (i < 4), 0);
    chk("overrun_set", overrun, 1);
    chk("full_valid", out_valid, 1);
    rdy_mode = 1;
    wait_drain();
    chk("overrun_sticky", overrun, 1);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    chk("overrun_clr", overrun, 0);

    // Disable mid-frame: partial frame discarded.
    bit_time(1'b0);
    bit_time(1'b1);
    bit_time(1'b0);
    rx_en = 1'b0;
    @(negedge clk);
    chk("disable_idle", busy, 0);
    rxd = 1'b1;
    repeat (8 * BITCLK) @(negedge clk);
    rx_en = 1'b1;
    repeat (2 * BITCLK) @(negedge clk);
    chk("disable_no_push", out_valid, 0);

    // Randomized formats, data and errors with a random consumer.
    rdy_mode = 2;
    for (int i = 0; i < 30; i++) begin
      send_frame(9'($urandom), 4'($urandom), 3'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 5) == 0), 1, 1);
    end
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Second-generation UART receiver with run-time frame format: 5..DATA_W data bits, none/even/odd/mark/space parity, and 1 or 2 stop bits. It takes a shared oversample tick from the baud generator and uses 3-sample majority voting at mid-bit. Completed frames and their per-frame error flags go into a small FIFO drained by a valid/ready handshake. It sits beside the existing transmitter, behind the UART register block.

Parameters:
DATA_W, 9, maximum data bits per frame; legal 5..9
OSR, 16, oversample ticks per bit; even, 8..32
FIFO_DEPTH, 4, receive FIFO entries; power of 2, >=2

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_en  in  1  receiver enable
sample_tick  in  1  one-clk pulse at OSR x baud
cfg_data_bits  in  4  data bits per frame, 5..DATA_W; values outside this range are clamped
cfg_parity  in  3  000 none, 001 even, 010 odd, 011 mark (1), 100 space (0); others = none
cfg_stop2  in  1  1 = two stop bits checked
rxd  in  1  serial input, asynchronous
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts head entry
out_data  out  DATA_W  received data, LSB = first bit, zero-extended above cfg_data_bits
out_parity_err  out  1  parity mismatch for head entry
out_frame_err  out  1  stop bit sampled 0 for head entry
out_break  out  1  break frame for head entry
overrun  out  1  sticky: frame dropped because FIFO was full
ovr_clr  in  1  clears overrun
busy  out  1  FSM not in IDLE

Behaviour:
- Reset values: all outputs 0; FIFO empty; FSM IDLE; armed=0; synchronizer flops = 1.
- rxd passes through a 2-flop synchronizer (rxd_s). All sampling uses rxd_s, and all FSM/counter updates occur only on clk edges where sample_tick=1 and rx_en=1.
- tick_cnt counts 0..OSR-1 within each bit. Votes are taken at counts OSR/2-1, OSR/2 and OSR/2+1. The voted bit is the majority of the 3 samples and is resolved at count OSR/2+1, including that tick's sample.
- armed: set when rxd_s=1 at a tick in IDLE; cleared on leaving IDLE. IDLE enters START only if armed and rxd_s=0, with tick_cnt=0. This blocks re-triggering on a held-low line.
- FSM states and transitions:
  - IDLE -> START: on the armed low condition above.
  - START: at vote, voted=1 -> IDLE (false start, nothing pushed). At tick_cnt=OSR-1 -> DATA, bit_idx=0.
  - DATA: at vote, shift the voted bit into bit position bit_idx. At OSR-1, bit_idx++. After bit cfg_data_bits-1 -> PARITY if parity is enabled, else STOP1.
  - PARITY: at vote, compare against the expected value: even = XOR of data; odd = ~XOR; mark = 1; space = 0. Mismatch sets perr. At OSR-1 -> STOP1.
  - STOP1: at vote, voted=0 sets ferr. If cfg_stop2=0, push the frame and -> IDLE immediately at the vote tick. Otherwise, at OSR-1 -> STOP2.
  - STOP2: at vote, voted=0 sets ferr; push the frame; -> IDLE.
- Break: data all 0, parity bit 0 (if enabled) and STOP1 vote 0 sets brk=1. ferr is also 1.
- cfg_* is sampled at the IDLE->START transition and held for the frame. Changes mid-frame have no effect.
- Push/pop and FIFO:
  - Push writes {data, perr, ferr, brk}. out_valid rises on the clk edge after the push tick (latency 1 clk).
  - Pop occurs when out_valid & out_ready. The head outputs are registered/combinational from the FIFO read pointer.
  - Push while full with no pop in the same cycle: the frame is dropped and overrun is set (sticky).
  - Push and pop in the same cycle while full: both are accepted, count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - ovr_clr clears overrun. If ovr_clr and a new overrun occur in the same cycle, overrun is set.
- rx_en=0: FSM -> IDLE, counters and armed cleared, partial frame discarded. FIFO contents are retained and can still be popped.
- Asynchronous reset mid-frame: everything returns to reset values immediately.

Test Plan:
- OSR=16, 8N1, rxd sends 0xA5 -> one push; out_data=0x0A5, all error flags 0; out_valid high 1 clk after the STOP1 vote tick.
- 7E2 (cfg_data_bits=7, cfg_parity=001, cfg_stop2=1) sends 0x35 with a wrong parity bit -> out_data=0x035, out_parity_err=1, out_frame_err=0.
- 9-bit odd parity sends 0x1FF with a correct parity bit; second case with STOP2 driven low -> first entry data=0x1FF, no errors; second entry out_frame_err=1.
- Low glitch of 6 ticks on idle line -> START vote=1, no push, FSM back to IDLE, busy pulse only.
- rxd held low for 3 frame times -> exactly one entry with out_break=1, out_frame_err=1, data=0. No further frames until rxd returns high for at least 1 tick.
- FIFO_DEPTH=4, out_ready=0, send 5 frames -> 4 entries stored, overrun=1; pop all -> 4 entries in order. Then ovr_clr -> overrun=0. Then assert rx_en=0 mid-frame -> no push.
